// File: rtl/conv2d_stream_pe.sv
// Streaming 3x3 stride-1 convolution engine: CH_IN packed input channels into CH_OUT packed
// outputs, with runtime weights/bias, round/shift/saturate, valid/ready backpressure and frame_done.
module conv2d_stream_pe #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int PADDING = 1,
  parameter int CH_IN   = 1,
  parameter int CH_OUT  = 8,
  parameter int ACC_W   = 24,
  localparam int NW     = 9 * CH_IN * CH_OUT,
  localparam int WA_W   = (NW > 1) ? $clog2(NW) : 1,
  localparam int BA_W   = (CH_OUT > 1) ? $clog2(CH_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*CH_IN-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*CH_OUT-1:0]   out_data,
  output logic                  frame_done,
  input  logic                  relu_en,
  input  logic [3:0]            quant_shift,
  input  logic                  w_we,
  input  logic [WA_W-1:0]       w_addr,
  input  logic [7:0]            w_data,
  input  logic                  b_we,
  input  logic [BA_W-1:0]       b_addr,
  input  logic [15:0]           b_data,
  output logic                  busy,
  output logic                  cfg_err
);

  localparam int TOTAL_W = IMG_W + 2 * PADDING;
  localparam int TOTAL_H = IMG_H + 2 * PADDING;
  localparam int CW      = $clog2(TOTAL_W);
  localparam int RW      = $clog2(TOTAL_H);
  localparam int NT      = 9 * CH_IN;
  localparam int PW      = 17;
  localparam int XW      = ACC_W + 1;
  localparam logic signed [XW-1:0] U8_MAX = XW'(255);
  localparam logic signed [XW-1:0] S8_MAX = XW'(127);
  localparam logic signed [XW-1:0] S8_MIN = XW'(-128);
  localparam logic signed [XW-1:0] ZERO   = XW'(0);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          in_frame_q, relu_q, cfg_err_q;
  logic [3:0]    shift_q;

  logic signed [7:0]  wgt_q  [NW];
  logic signed [15:0] bias_q [CH_OUT];
  logic [8*CH_IN-1:0] lb0_q [TOTAL_W];
  logic [8*CH_IN-1:0] lb1_q [TOTAL_W];
  logic [7:0]         win_q [3][3][CH_IN];
  logic [7:0]         win_d [3][3][CH_IN];

  logic signed [PW-1:0]    prod_d    [CH_OUT][NT];
  logic signed [PW-1:0]    prod_p1_q [CH_OUT][NT];
  logic signed [ACC_W-1:0] acc_d     [CH_OUT];
  logic signed [ACC_W-1:0] acc_p2_q  [CH_OUT];
  logic                    vld_p1_q, vld_p2_q, last_p1_q, last_p2_q, last_q;
  logic                    relu_p1_q, relu_p2_q;
  logic [3:0]              shift_p1_q, shift_p2_q;
  logic                    out_valid_q;
  logic [8*CH_OUT-1:0]     out_data_q, out_d;

  logic stall, adv, acc_beat, first_beat, col_last, row_last, win_done, cur_relu;
  logic [3:0] cur_shift;

  function automatic logic signed [XW-1:0] round_shift(input logic signed [ACC_W-1:0] v,
                                                       input logic [3:0] sh);
    logic signed [XW-1:0] t;
    t = XW'(v);
    if (sh != 4'd0) t = t + (XW'(1) << (sh - 4'd1));
    return t >>> sh;
  endfunction

  function automatic logic [7:0] saturate(input logic signed [XW-1:0] v, input logic relu);
    logic [7:0] r;
    r = v[7:0];
    if (relu) begin
      if (v < ZERO) r = 8'd0;
      else if (v > U8_MAX) r = 8'd255;
    end else begin
      if (v < S8_MIN) r = 8'h80;
      else if (v > S8_MAX) r = 8'h7f;
    end
    return r;
  endfunction

  assign stall      = out_valid_q && !out_ready;
  assign adv        = !stall;
  assign in_ready   = rst_n && adv;
  assign acc_beat   = in_valid && in_ready;
  assign first_beat = (col_q == '0) && (row_q == '0);
  assign col_last   = (col_q == CW'(TOTAL_W - 1));
  assign row_last   = (row_q == RW'(TOTAL_H - 1));
  assign win_done   = (col_q >= CW'(2)) && (row_q >= RW'(2));
  assign cur_relu   = first_beat ? relu_en : relu_q;
  assign cur_shift  = first_beat ? quant_shift : shift_q;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = out_valid_q && out_ready && last_q;
  assign busy       = in_frame_q || vld_p1_q || vld_p2_q || out_valid_q;
  assign cfg_err    = cfg_err_q;

  // Window column enters from the line buffers and the live beat; older columns shift left.
  always_comb begin
    win_d = win_q;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 2; kx++)
        for (int c = 0; c < CH_IN; c++)
          win_d[ky][kx][c] = win_q[ky][kx+1][c];
    for (int c = 0; c < CH_IN; c++) begin
      win_d[0][2][c] = lb1_q[col_q][8*c +: 8];
      win_d[1][2][c] = lb0_q[col_q][8*c +: 8];
      win_d[2][2][c] = in_data[8*c +: 8];
    end
  end

  // Stage 1: multiply
  always_comb begin
    for (int o = 0; o < CH_OUT; o++)
      for (int c = 0; c < CH_IN; c++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            prod_d[o][c*9 + ky*3 + kx] = PW'($signed({1'b0, win_d[ky][kx][c]}))
                                         * PW'(wgt_q[(o*CH_IN + c)*9 + ky*3 + kx]);
  end

  // Stage 2: adder tree plus bias
  always_comb begin
    for (int o = 0; o < CH_OUT; o++) begin
      acc_d[o] = ACC_W'(bias_q[o]);
      for (int t = 0; t < NT; t++) acc_d[o] = acc_d[o] + ACC_W'(prod_p1_q[o][t]);
    end
  end

  // Stage 3: round, shift, saturate
  always_comb begin
    out_d = '0;
    for (int o = 0; o < CH_OUT; o++)
      out_d[8*o +: 8] = saturate(round_shift(acc_p2_q[o], shift_p2_q), relu_p2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      in_frame_q  <= 1'b0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      cfg_err_q   <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      last_p2_q   <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cfg_err_q <= (w_we || b_we) && busy;
      if (acc_beat) begin
        col_q <= col_last ? '0 : col_q + CW'(1);
        if (col_last) row_q <= row_last ? '0 : row_q + RW'(1);
        if (first_beat) begin
          relu_q     <= relu_en;
          shift_q    <= quant_shift;
          in_frame_q <= 1'b1;
        end else if (col_last && row_last) begin
          in_frame_q <= 1'b0;
        end
      end
      if (adv) begin
        vld_p1_q    <= acc_beat && win_done;
        last_p1_q   <= acc_beat && col_last && row_last;
        vld_p2_q    <= vld_p1_q;
        last_p2_q   <= last_p1_q;
        out_valid_q <= vld_p2_q;
        last_q      <= last_p2_q;
        if (vld_p2_q) out_data_q <= out_d;
      end
    end
  end

  // Datapath and coefficient storage carry no reset; out-of-range addresses are ignored.
  always_ff @(posedge clk) begin
    if (acc_beat) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= in_data;
      win_q        <= win_d;
    end
    if (adv) begin
      prod_p1_q  <= prod_d;
      relu_p1_q  <= cur_relu;
      shift_p1_q <= cur_shift;
      acc_p2_q   <= acc_d;
      relu_p2_q  <= relu_p1_q;
      shift_p2_q <= shift_p1_q;
    end
    if (w_we && !busy && (int'(w_addr) < NW)) wgt_q[w_addr] <= w_data;
    if (b_we && !busy && (int'(b_addr) < CH_OUT)) bias_q[b_addr] <= b_data;
  end

endmodule

// File: tb/tb_conv2d_stream_pe.sv
// Bench for conv2d_stream_pe (4x4 image, pad 1, 2 in / 2 out channels) against a
// plain-arithmetic convolution model, with random gaps, backpressure and config pokes.
module tb_conv2d_stream_pe;
  localparam int IMG_W = 4, IMG_H = 4, PAD = 1, CI = 2, CO = 2, ACC_W = 24;
  localparam int TW = IMG_W + 2*PAD, TH = IMG_H + 2*PAD, NW = 9*CI*CO;
  localparam int WA_W = $clog2(NW), BA_W = (CO > 1) ? $clog2(CO) : 1;

  logic clk = 1'b0, rst_n;
  logic in_valid, in_ready, out_valid, out_ready, frame_done, relu_en;
  logic [8*CI-1:0] in_data;
  logic [8*CO-1:0] out_data;
  logic [3:0] quant_shift;
  logic w_we, b_we, busy, cfg_err;
  logic [WA_W-1:0] w_addr;
  logic [7:0] w_data;
  logic [BA_W-1:0] b_addr;
  logic [15:0] b_data;

  always #5 clk = ~clk;

  conv2d_stream_pe #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PADDING(PAD), .CH_IN(CI), .CH_OUT(CO),
                     .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .frame_done(frame_done),
    .relu_en(relu_en), .quant_shift(quant_shift), .w_we(w_we), .w_addr(w_addr),
    .w_data(w_data), .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .busy(busy),
    .cfg_err(cfg_err));

  typedef struct { logic [8*CO-1:0] data; bit last; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [8*CO-1:0] got_q[$];
  int n_cmp = 0, n_mis = 0;
  int img[TH][TW][CI];
  int wt[NW];
  int bs[CO];
  int rdy_mode = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic int sat(input int v, input bit relu);
    if (relu) return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    return (v < -128) ? -128 : ((v > 127) ? 127 : v);
  endfunction

  task automatic model_frame(input bit relu, input int sh);
    exp_t e;
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) begin
        e.data = '0;
        for (int o = 0; o < CO; o++) begin
          int acc;
          acc = bs[o];
          for (int c = 0; c < CI; c++)
            for (int ky = 0; ky < 3; ky++)
              for (int kx = 0; kx < 3; kx++)
                acc += img[y+ky][x+kx][c] * wt[(o*CI + c)*9 + ky*3 + kx];
          if (sh > 0) acc += 1 << (sh - 1);
          acc = acc >>> sh;
          e.data[8*o +: 8] = 8'(sat(acc, relu));
        end
        e.last = (y == IMG_H-1) && (x == IMG_W-1);
        exp_q.push_back(e);
      end
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        for (int k = 0; k < CI; k++)
          case (mode)
            0: img[r][c][k] = (r >= PAD && r < TH-PAD && c >= PAD && c < TW-PAD) ? 1 : 0;
            1: img[r][c][k] = 255;
            default: img[r][c][k] = $urandom_range(0, 255);
          endcase
  endtask

  task automatic fill_wt(input bit rnd, input int v);
    for (int i = 0; i < NW; i++) wt[i] = rnd ? ($urandom_range(0, 255) - 128) : v;
  endtask

  task automatic fill_bias(input bit rnd, input int v);
    for (int o = 0; o < CO; o++) bs[o] = rnd ? ($urandom_range(0, 4095) - 2048) : v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (mon_en && rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("frame_done", frame_done, mon_e.last);
          got_q.push_back(out_data);
        end
      end else if (frame_done) begin
        check("frame_done_no_handshake", frame_done, 0);
      end
    end
  end

  // Simultaneous weight and bias strobes for the first CO addresses.
  task automatic load_params();
    for (int i = 0; i < NW; i++) begin
      w_we = 1'b1; w_addr = WA_W'(i); w_data = 8'(wt[i]);
      b_we = (i < CO); b_addr = BA_W'((i < CO) ? i : 0); b_data = 16'(bs[(i < CO) ? i : 0]);
      tick();
      w_we = 1'b0; b_we = 1'b0;
      check("cfg_err_idle", cfg_err, 0);
    end
  endtask

  task automatic send_frame(input bit relu, input int sh, input int gap_pct,
                            input int poke_at, input int abort_at);
    int n; bit ok; int budget;
    n = 0;
    relu_en = relu; quant_shift = 4'(sh);
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++) begin
        if ($urandom_range(0, 99) < gap_pct) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 2)) tick();
        end
        in_valid = 1'b1;
        for (int k = 0; k < CI; k++) in_data[8*k +: 8] = 8'(img[r][c][k]);
        ok = 1'b0; budget = 0;
        while (!ok && budget < 300) begin
          @(negedge clk);
          ok = in_ready;
          tick();
          budget++;
        end
        if (!ok) check("accept_timeout", ok, 1);
        in_valid = 1'b0;
        n++;
        if (n == 1) begin
          relu_en = 1'($urandom_range(0, 1));
          quant_shift = 4'($urandom_range(0, 15));
        end
        if (n == poke_at) begin
          check("busy_mid_frame", busy, 1);
          w_we = 1'b1; w_addr = '0; w_data = 8'(wt[0] + 37);
          b_we = 1'b1; b_addr = '0; b_data = 16'(bs[0] + 1000);
          tick();
          w_we = 1'b0; b_we = 1'b0;
          check("cfg_err_pulse", cfg_err, 1);
          tick();
          check("cfg_err_clear", cfg_err, 0);
        end
        if (n == abort_at) begin
          rst_n = 1'b0;
          #1;
          check("abort_out_valid", out_valid, 0);
          check("abort_busy", busy, 0);
          check("abort_in_ready", in_ready, 0);
          check("abort_frame_done", frame_done, 0);
          exp_q.delete();
          tick(); tick();
          rst_n = 1'b1;
          #1;
          check("abort_release_in_ready", in_ready, 1);
          return;
        end
      end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 1000) begin
      tick();
      budget++;
    end
    check("drain_done", exp_q.size(), 0);
    check("busy_after_frame", busy, 0);
  endtask

  task automatic frame(input bit relu, input int sh, input int gap, input int poke,
                       input int abort_at, input bit do_drain);
    model_frame(relu, sh);
    send_frame(relu, sh, gap, poke, abort_at);
    if (do_drain) drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; relu_en = 1'b0; quant_shift = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0; b_we = 1'b0; b_addr = '0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    tick();
    mon_en = 1'b1;

    fill_img(0); fill_wt(0, 1); fill_bias(0, 0); load_params();
    got_q.delete(); frame(1, 0, 0, 0, 0, 1);
    check("ones_corner", got_q[0], 16'h0808);
    check("ones_edge", got_q[1], 16'h0c0c);
    check("ones_centre", got_q[5], 16'h1212);
    check("ones_last_corner", got_q[15], 16'h0808);
    check("ones_beat_count", got_q.size(), 16);

    fill_wt(0, -1); load_params();
    got_q.delete(); frame(1, 0, 0, 0, 0, 1);
    check("neg_relu_centre", got_q[5], 16'h0000);
    got_q.delete(); frame(0, 0, 0, 0, 0, 1);
    check("neg_signed_corner", got_q[0], 16'hf8f8);
    check("neg_signed_edge", got_q[1], 16'hf4f4);
    check("neg_signed_centre", got_q[5], 16'heeee);

    fill_img(1); fill_wt(0, 127); load_params();
    got_q.delete(); frame(1, 0, 0, 0, 0, 1);
    check("sat_relu", got_q[5], 16'hffff);
    got_q.delete(); frame(0, 0, 0, 0, 0, 1);
    check("sat_signed", got_q[5], 16'h7f7f);
    got_q.delete(); frame(1, 8, 0, 0, 0, 1);
    check("sat_shift8", got_q[0], 16'hffff);

    fill_img(2); fill_wt(0, 0); fill_bias(0, 100); load_params();
    got_q.delete(); frame(1, 2, 0, 0, 0, 1);
    check("bias100_shift2", got_q[7], 16'h1919);
    fill_bias(0, 102); load_params();
    got_q.delete(); frame(0, 2, 0, 0, 0, 1);
    check("bias102_round", got_q[7], 16'h1a1a);

    // Backpressure: hold out_ready low mid-frame.
    fill_img(2); fill_wt(1, 0); fill_bias(1, 0); load_params();
    got_q.delete(); model_frame(0, 6);
    fork
      send_frame(0, 6, 0, 0, 0);
      begin
        int b, seen;
        b = 0; seen = 0;
        while (got_q.size() < 6 && b < 500) begin @(posedge clk); b++; end
        rdy_mode = 2;
        repeat (5) begin
          @(negedge clk);
          if (out_valid) begin
            seen++;
            check("stall_in_ready", in_ready, 0);
            check("stall_hold", out_data, exp_q[0].data);
          end
        end
        check("stall_seen", seen > 0, 1);
        rdy_mode = 0;
      end
    join
    drain();
    check("stall_beat_count", got_q.size(), 16);

    rdy_mode = 1;
    fill_img(2); frame(1, 3, 10, 10, 0, 1);

    fill_img(2); frame(0, 5, 0, 0, 20, 0);
    fill_img(2); frame(1, 4, 0, 0, 0, 1);

    for (int i = 0; i < 3; i++) begin
      fill_wt(1, 0); fill_bias(1, 0); load_params();
      fill_img(2); frame(1'($urandom_range(0, 1)), $urandom_range(0, 15), 20, 0, 0, 0);
      fill_img(2); frame(1'($urandom_range(0, 1)), $urandom_range(0, 15), 20, 0, 0, 1);
    end
    rdy_mode = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/conv2d_stream_pe.md
Name: conv2d_stream_pe

Overview:
- Parametrised next-generation 3x3 stride-1 convolution engine: CH_IN input channels accumulated into CH_OUT output channels, all in parallel.
- Adds runtime weight/bias loading, per-channel bias, rounding, selectable ReLU/signed output, valid/ready backpressure and frame-done signalling.
- Sits between the padded pixel streamer (upstream) and the pooling/next conv stage (downstream).

Parameters:
- IMG_W, 28, output image width in pixels.
- IMG_H, 28, output image height in pixels.
- PADDING, 1, border width already present in the input stream. TOTAL_W = IMG_W+2*PADDING, TOTAL_H = IMG_H+2*PADDING.
- CH_IN, 1, number of input channels, packed on in_data.
- CH_OUT, 8, number of output channels, packed on out_data.
- ACC_W, 24, accumulator width. Must be >= 17+clog2(9*CH_IN).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  pixel beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  8*CH_IN  unsigned pixels; channel c occupies bits [8c+7:8c].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_data  output  8*CH_OUT  results; channel o occupies bits [8o+7:8o].
- frame_done  output  1  one-cycle pulse, coincident with the handshake of the last output pixel.
- relu_en  input  1  1 selects ReLU with unsigned saturation; 0 selects signed int8 saturation.
- quant_shift  input  4  right-shift amount, 0..15.
- w_we  input  1  weight write strobe.
- w_addr  input  clog2(9*CH_IN*CH_OUT)  address = (o*CH_IN+c)*9 + ky*3 + kx.
- w_data  input  8  signed weight.
- b_we  input  1  bias write strobe.
- b_addr  input  clog2(CH_OUT)  bias channel.
- b_data  input  16  signed bias.
- busy  output  1  a frame is in progress or the pipeline holds valid data.
- cfg_err  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset values: in_ready=0 during reset and 1 after; out_valid=0, out_data=0, frame_done=0, busy=0, cfg_err=0. Counters are cleared. Weight and bias RAM contents are not reset.
- Input stream is raster order over TOTAL_W x TOTAL_H, padding included. A beat is accepted when in_valid && in_ready.
- Stall: in_ready = !(out_valid && !out_ready). The whole pipeline (line buffers, window, MAC, output register) advances only when not stalled. Cycles with in_valid low insert bubbles.
- col/row counters advance per accepted beat. col wraps at TOTAL_W-1. row wraps at TOTAL_H-1, and the frame ends on that wrap.
- A window is complete when the accepted beat has row>=2 and col>=2. The result is the output pixel (row-2, col-2).
- Window data: two line buffers of TOTAL_W entries, each 8*CH_IN wide, plus a 3x3xCH_IN shift window.
- Pipeline:
  - Stage 1: multiply.
  - Stage 2: adder tree over 9*CH_IN products, plus bias sign-extended to ACC_W.
  - Stage 3: round, shift, saturate into the output register.
  - out_valid rises exactly 3 unstalled cycles after the window-completing beat.
- Rounding: when quant_shift>0, add 1<<(quant_shift-1) before the arithmetic right shift (round half up).
- Saturation:
  - relu_en=1: values <0 become 0; values >255 become 255.
  - relu_en=0: clamp to [-128,127], two's complement.
- relu_en and quant_shift are sampled at the first accepted beat of a frame and held for that frame.
- busy rises on the first accepted beat. It falls the cycle after the frame_done handshake.
- Weight/bias writes are honoured only when busy=0. A write while busy=1 is dropped and pulses cfg_err the next cycle. Simultaneous w_we and b_we are both honoured.
- An output of IMG_W*IMG_H beats per frame; frame_done accompanies the last one. Back-to-back frames are allowed with no gap.
- Reset asserted mid-frame aborts the frame: counters and pipeline valid bits clear immediately, and no frame_done is issued.

Test Plan:
- IMG 4x4, PADDING 1, CH_IN 2, CH_OUT 2. All weights 1, biases 0, shift 0, relu_en 1. Interior pixels 1, border 0 -> 16 beats: corners 8, edges 12, centre 18. frame_done on the 16th beat.
- Same setup, weights -1 -> relu_en=1 gives all 0; relu_en=0 gives -8/-12/-18.
- Pixels 255, weights 127, shift 0 -> saturates to 255 with relu_en=1 and 127 with relu_en=0. Shift 8 with bias 0: centre 18*255*127=582930 -> round half up gives 2277, then saturates to 255.
- Bias 100, weights 0, shift 2 -> every output 25 (100>>2). Bias 102 -> 26 (rounding).
- out_ready held low for 5 cycles mid-frame -> in_ready low, out_data stable, no beat lost or duplicated. Output sequence identical to the unstalled run.
- w_we during a frame -> cfg_err pulses, outputs unchanged. rst_n pulsed at beat 20 -> out_valid=0 and busy=0 immediately. The next full frame is correct.
